hc_sr04_echo_emu: RTL and testbench
===================================

# hc_sr04_echo_emu

Synthesizable emulator of the HC-SR04 ultrasonic sensor's side of the trigger/echo protocol. It accepts the trigger pulse produced by the `hc_sr04` controller and validates its width. It then returns an echo pulse whose width encodes a programmable distance in centimetres. It sits in loopback and bring-up builds in place of the physical sensor, so the controller and display path can be exercised without hardware.

## Interface
- `CYC_PER_CM`, 261: clock cycles of echo per centimetre; matches the controller's cm conversion.
- `TRIG_MIN_CYC`, 500: minimum accepted trigger high width in cycles (10 µs at 50 MHz).
- `BURST_CYC`, 10_000: delay from trigger fall to echo rise (8 × 40 kHz burst, 200 µs).
- `MAX_CM`, 400: largest in-range distance.
- `TIMEOUT_CYC`, 1_900_000: echo width for out-of-range or zero distance (38 ms).
- `HOLDOFF_CYC`, 500_000: dead time after echo fall before a new trigger is accepted (10 ms).
- `clk` input 1: system clock.
- `rst` input 1: reset, synchronous, active-low.
- `trigger` input 1: trigger from controller, asynchronous to `clk`.
- `dist_cm` input 9: distance to emulate, sampled once per measurement.
- `dur` output 1: echo pulse to controller.
- `busy` output 1: high in every state except IDLE.
- `trig_err` output 1: one-cycle pulse on a rejected trigger.

## Operation
- `trigger` passes through a 2-flop synchronizer into `trig_s`. Rise and fall detection use `trig_s` and its registered copy.
- **IDLE**
  - On a `trig_s` rise: clear the width counter and go to TRIG_HI.
- **TRIG_HI**
  - Width counter increments each cycle `trig_s` is high, saturating at `TRIG_MIN_CYC`.
  - On a `trig_s` fall with width ≥ `TRIG_MIN_CYC`: latch `dist_cm` and go to BURST.
  - On a `trig_s` fall with width < `TRIG_MIN_CYC`: pulse `trig_err` and return to IDLE.
- **BURST**
  - Counts `BURST_CYC` cycles, then goes to ECHO.
  - In the same cycle the latched distance is converted: echo_len = `TIMEOUT_CYC` if dist == 0 or dist > `MAX_CM`, else dist × `CYC_PER_CM`.
  - The product is registered, 32-bit unsigned, no truncation.
- **ECHO**
  - `dur` is high; a down-counter loaded with echo_len runs.
  - When it expires, `dur` falls and the block goes to HOLDOFF.
- **HOLDOFF**
  - Counts `HOLDOFF_CYC` cycles, then returns to IDLE.
- Trigger rises in BURST, ECHO or HOLDOFF are ignored and pulse `trig_err`.
- `dist_cm` changes after the latch have no effect on the current measurement.
- Trigger width is measured in synchronized cycles. Sub-cycle glitches shorter than one clock may be missed and are not errors.

## Timing
- Reset values: `dur`=0, `busy`=0, `trig_err`=0, state IDLE, all counters 0.
- A reset asserted mid-operation forces `dur` low on the next clock edge and aborts the measurement. No echo is resumed.
- Synchronizer latency: 2 cycles, `trigger` to `trig_s`.
- Let t0 be the cycle in which the `trig_s` fall is detected:
  - `dur` rises at t0 + `BURST_CYC`.
  - `dur` is high for exactly echo_len consecutive cycles.
- `busy` rises the cycle after the `trig_s` rise is detected. It falls at echo fall + `HOLDOFF_CYC`.
- Width boundaries:
  - Width = `TRIG_MIN_CYC` is accepted.
  - Width = `TRIG_MIN_CYC`−1 is rejected.
  - Width above `TRIG_MIN_CYC` is accepted; the counter saturates and does not wrap.
- `trig_err` is high for exactly one cycle per rejected trigger. It is never asserted together with an echo start.
- A trigger rise in the same cycle HOLDOFF completes is ignored; only a rise seen in IDLE starts a measurement.

## Structure
- Package `hc_sr04_pkg` holds:
  - the state enum (IDLE, TRIG_HI, BURST, ECHO, HOLDOFF);
  - the default timing constants (10 µs, 200 µs, 38 ms, 10 ms at 50 MHz);
  - the `CYC_PER_CM` default, shared with the controller.
- Sub-module `hc_sr04_edge_sync` contains the 2-flop synchronizer plus rise/fall detector. It uses the same `rst` polarity.
- The FSM, counters and multiplier stay in the top module.

## Test plan
- Trigger high 550 cycles, `dist_cm`=100 → `dur` rises 10_000 cycles after t0 and is high exactly 26_100 cycles; `busy` then stays high 500_000 more cycles.
- Trigger widths 499 and 500, `dist_cm`=10:
  - 499 → one `trig_err` pulse, no `dur`;
  - 500 → `dur` high 2_610 cycles.
- `dist_cm`=0 and `dist_cm`=401 → `dur` high 1_900_000 cycles each; `dist_cm`=400 → `dur` high 104_400 cycles.
- Second trigger during ECHO and during HOLDOFF → one `trig_err` each; first echo width unchanged; no second echo until after IDLE.
- `dist_cm` changed from 50 to 300 during BURST → echo width 13_050 cycles.
- `rst` low for one cycle mid-ECHO → `dur`, `busy` low next cycle; subsequent valid trigger produces a correct full echo.

Source files
------------

// File: rtl/hc_sr04_pkg.sv
// Shared types and default timing for the HC-SR04 sensor emulator and controller.
// Default cycle counts assume a 50 MHz system clock.
package hc_sr04_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG_HI,
    BURST,
    ECHO,
    HOLDOFF
  } state_e;

  localparam int unsigned CNT_W  = 32;
  localparam int unsigned DIST_W = 9;

  localparam int unsigned CYC_PER_CM_DEF   = 261;
  localparam int unsigned TRIG_MIN_CYC_DEF = 500;
  localparam int unsigned BURST_CYC_DEF    = 10_000;
  localparam int unsigned MAX_CM_DEF       = 400;
  localparam int unsigned TIMEOUT_CYC_DEF  = 1_900_000;
  localparam int unsigned HOLDOFF_CYC_DEF  = 500_000;

endpackage

// File: rtl/hc_sr04_edge_sync.sv
// Two-flop synchronizer for the asynchronous trigger, followed by a
// registered-copy rise/fall detector on the synchronized level.
module hc_sr04_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic dly_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      dly_q  <= 1'b0;
    end else begin
      meta_q <= sig_i;
      sync_q <= meta_q;
      dly_q  <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = sync_q & ~dly_q;
  assign fall_o = ~sync_q & dly_q;

endmodule

// File: rtl/hc_sr04_echo_emu.sv
// HC-SR04 sensor emulator: validates the trigger width, waits out the burst,
// then returns an echo whose width encodes the programmed distance.
module hc_sr04_echo_emu
  import hc_sr04_pkg::*;
#(
  parameter int unsigned CYC_PER_CM   = CYC_PER_CM_DEF,
  parameter int unsigned TRIG_MIN_CYC = TRIG_MIN_CYC_DEF,
  parameter int unsigned BURST_CYC    = BURST_CYC_DEF,
  parameter int unsigned MAX_CM       = MAX_CM_DEF,
  parameter int unsigned TIMEOUT_CYC  = TIMEOUT_CYC_DEF,
  parameter int unsigned HOLDOFF_CYC  = HOLDOFF_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trigger,
  input  logic [DIST_W-1:0] dist_cm,
  output logic              dur,
  output logic              busy,
  output logic              trig_err
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DIST_W-1:0]  dist_q;
  logic [CNT_W-1:0]   echo_len_q;
  logic               dist_ld;
  logic               trig_s, trig_rise, trig_fall;

  function automatic logic [CNT_W-1:0] echo_len_f(input logic [DIST_W-1:0] d);
    if (d == '0 || CNT_W'(d) > MAX_CM) return TIMEOUT_CYC;
    return CNT_W'(d) * CYC_PER_CM;
  endfunction

  hc_sr04_edge_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .sig_i  (trigger),
    .sync_o (trig_s),
    .rise_o (trig_rise),
    .fall_o (trig_fall)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Distance and echo length are pure data; only the FSM needs a reset.
  always_ff @(posedge clk) begin
    if (dist_ld) dist_q <= dist_cm;
    echo_len_q <= echo_len_f(dist_q);
  end

  // One counter serves every state. The rise cycle counts as the first
  // trigger-high cycle and the fall cycle as the first burst cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dist_ld  = 1'b0;
    trig_err = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (trig_rise) begin
          state_d = TRIG_HI;
          cnt_d   = 32'd1;
        end
      end
      TRIG_HI: begin
        if (trig_fall) begin
          if (cnt_q >= TRIG_MIN_CYC) begin
            dist_ld = 1'b1;
            cnt_d   = 32'd1;
            state_d = BURST;
          end else begin
            trig_err = 1'b1;
            cnt_d    = '0;
            state_d  = IDLE;
          end
        end else if (trig_s && cnt_q < TRIG_MIN_CYC) begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      BURST: begin
        trig_err = trig_rise;
        if (cnt_q >= BURST_CYC - 1) begin
          state_d = ECHO;
          cnt_d   = echo_len_q;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ECHO: begin
        trig_err = trig_rise;
        if (cnt_q <= 32'd1) begin
          state_d = HOLDOFF;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      HOLDOFF: begin
        trig_err = trig_rise;
        if (cnt_q >= HOLDOFF_CYC - 1) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign dur  = (state_q == ECHO);
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_hc_sr04_echo_emu.sv
// Randomized bench for hc_sr04_echo_emu with shortened timing constants; expected
// edge cycles come from the protocol rules applied to the driven trigger times.
module tb_hc_sr04_echo_emu;

  localparam int unsigned CPC   = 3;
  localparam int unsigned TMIN  = 20;
  localparam int unsigned BRST  = 40;
  localparam int unsigned MAXCM = 400;
  localparam int unsigned TOUT  = 1500;
  localparam int unsigned HOLD  = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       trigger = 1'b0;
  logic [8:0] dist_cm = '0;
  logic       dur, busy, trig_err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int kr, kf;

  int   dur_rise_q[$], dur_fall_q[$], busy_rise_q[$], busy_fall_q[$], err_q[$];
  logic dur_prev = 1'b0, busy_prev = 1'b0;

  hc_sr04_echo_emu #(
    .CYC_PER_CM   (CPC),
    .TRIG_MIN_CYC (TMIN),
    .BURST_CYC    (BRST),
    .MAX_CM       (MAXCM),
    .TIMEOUT_CYC  (TOUT),
    .HOLDOFF_CYC  (HOLD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .trigger  (trigger),
    .dist_cm  (dist_cm),
    .dur      (dur),
    .busy     (busy),
    .trig_err (trig_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dur && !dur_prev)   dur_rise_q.push_back(cyc);
    if (!dur && dur_prev)   dur_fall_q.push_back(cyc);
    if (busy && !busy_prev) busy_rise_q.push_back(cyc);
    if (!busy && busy_prev) busy_fall_q.push_back(cyc);
    if (trig_err)           err_q.push_back(cyc);
    dur_prev  <= dur;
    busy_prev <= busy;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_len(input int d);
    if (d == 0 || d > int'(MAXCM)) return TOUT;
    return d * CPC;
  endfunction

  task automatic clear_q();
    dur_rise_q.delete();
    dur_fall_q.delete();
    busy_rise_q.delete();
    busy_fall_q.delete();
    err_q.delete();
  endtask

  task automatic pulse(input int w);
    @(posedge clk);
    #1 trigger = 1'b1;
    kr = cyc;
    repeat (w) @(posedge clk);
    #1 trigger = 1'b0;
    kf = cyc;
  endtask

  task automatic wait_idle(input string tag);
    int i = 0;
    while (busy && i < 5000) begin
      @(negedge clk);
      i++;
    end
    check_eq({tag, ":idle"}, busy, 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_dur(input string tag, input logic lvl);
    int i = 0;
    while (dur !== lvl && i < 5000) begin
      @(negedge clk);
      i++;
    end
    check_eq({tag, ":wait_dur"}, dur, lvl);
  endtask

  task automatic check_accept(input string tag, input int d, input int nerr);
    int len = ref_len(d);
    check_eq({tag, ":n_rise"}, dur_rise_q.size(), 1);
    check_eq({tag, ":n_err"}, err_q.size(), nerr);
    check_eq({tag, ":n_busy_rise"}, busy_rise_q.size(), 1);
    if (busy_rise_q.size() > 0)
      check_eq({tag, ":busy_rise_cyc"}, busy_rise_q[0], kr + 3);
    if (dur_rise_q.size() > 0 && dur_fall_q.size() > 0) begin
      check_eq({tag, ":rise_cyc"}, dur_rise_q[0], kf + 2 + BRST);
      check_eq({tag, ":echo_len"}, dur_fall_q[0] - dur_rise_q[0], len);
      if (busy_fall_q.size() > 0)
        check_eq({tag, ":busy_fall_cyc"}, busy_fall_q[0], dur_fall_q[0] + HOLD);
    end
  endtask

  task automatic check_reject(input string tag);
    check_eq({tag, ":n_rise"}, dur_rise_q.size(), 0);
    check_eq({tag, ":n_err"}, err_q.size(), 1);
    if (err_q.size() > 0) check_eq({tag, ":err_cyc"}, err_q[0], kf + 2);
  endtask

  task automatic run_meas(input string tag, input int w, input int d);
    clear_q();
    dist_cm = 9'(d);
    pulse(w);
    wait_idle(tag);
    if (w >= int'(TMIN)) check_accept(tag, d, 0);
    else                 check_reject(tag);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int kr0, kf0, f, w, d;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst:dur", dur, 0);
    check_eq("rst:busy", busy, 0);
    check_eq("rst:trig_err", trig_err, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);

    run_meas("basic", TMIN + 30, 100);
    run_meas("w_min_m1", TMIN - 1, 10);
    run_meas("w_min", TMIN, 10);
    run_meas("w_long", TMIN + 250, 17);
    run_meas("d0", TMIN + 2, 0);
    run_meas("d401", TMIN + 2, 401);
    run_meas("d400", TMIN + 2, 400);
    run_meas("d1", TMIN + 2, 1);

    // Distance changes after the latch must not affect the echo.
    clear_q();
    dist_cm = 9'd50;
    pulse(TMIN + 5);
    repeat (5) @(posedge clk);
    #1 dist_cm = 9'd300;
    wait_idle("dchg");
    check_accept("dchg", 50, 0);

    // Extra triggers during ECHO and HOLDOFF are rejected without disturbing the echo.
    clear_q();
    dist_cm = 9'd400;
    pulse(TMIN + 5);
    kr0 = kr;
    kf0 = kf;
    wait_dur("intf_echo", 1'b1);
    pulse(TMIN + 5);
    wait_dur("intf_fall", 1'b0);
    repeat (5) @(negedge clk);
    pulse(TMIN + 5);
    wait_idle("intf");
    kr = kr0;
    kf = kf0;
    check_accept("intf", 400, 2);
    repeat (3) @(negedge clk);

    // A rise detected in the final HOLDOFF cycle is rejected, not started.
    clear_q();
    dist_cm = 9'd5;
    pulse(TMIN + 2);
    wait_dur("hold_edge_echo", 1'b1);
    wait_dur("hold_edge_fall", 1'b0);
    f = (dur_fall_q.size() > 0) ? dur_fall_q[0] : cyc;
    while (cyc < f + int'(HOLD) - 4) @(negedge clk);
    pulse(TMIN + 5);
    wait_idle("hold_edge");
    repeat (40) @(negedge clk);
    check_eq("hold_edge:busy", busy, 0);
    check_eq("hold_edge:n_rise", dur_rise_q.size(), 1);
    check_eq("hold_edge:n_busy_rise", busy_rise_q.size(), 1);
    check_eq("hold_edge:n_err", err_q.size(), 1);
    if (err_q.size() > 0) check_eq("hold_edge:err_cyc", err_q[0], f + HOLD - 1);

    // Reset in the middle of an echo aborts it.
    clear_q();
    dist_cm = 9'd200;
    pulse(TMIN + 3);
    wait_dur("rst_mid", 1'b1);
    repeat (50) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_eq("rst_mid:dur", dur, 0);
    check_eq("rst_mid:busy", busy, 0);
    repeat (5) @(negedge clk);
    run_meas("post_rst", TMIN + 2, 7);

    for (int i = 0; i < 14; i++) begin
      w = int'($urandom_range(TMIN - 3, TMIN + 30));
      d = int'($urandom_range(0, 511));
      run_meas($sformatf("rnd%0d_w%0d_d%0d", i, w, d), w, d);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
